// File: rtl/mem_pkg.sv
// Shared definitions for the unified memory and the control state machine.
package mem_pkg;

    // Access size/extension codes as carried on func3.
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_func3_t;

    // Memory-mapped registers at the very top of the address space.
    localparam logic [31:0] MMIO_BASE   = 32'hFFFF_FFF0;
    localparam logic [31:0] MMIO_MICROS = 32'hFFFF_FFF4;
    localparam logic [31:0] MMIO_MILLIS = 32'hFFFF_FFF8;
    localparam logic [31:0] MMIO_LEDS   = 32'hFFFF_FFFC;

    // Source of the registered load result.
    typedef enum logic [1:0] {
        RSEL_ZERO,
        RSEL_RAM,
        RSEL_MMIO
    } rsel_t;

    // Pick the addressed byte/half out of a word and extend it.
    // Encodings other than B/H/BU/HU return the whole word.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (mem_func3_t'(f3))
            MEM_B:   r = {{24{b[7]}}, b};
            MEM_BU:  r = {24'h0, b};
            MEM_H:   r = {{16{h[15]}}, h};
            MEM_HU:  r = {16'h0, h};
            MEM_W:   r = word;
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/memory_unit_mmio_timers.sv
// Free-running microsecond and millisecond counters derived from the core clock.
module mmio_timers #(
    parameter int CLK_FREQ_HZ = 12000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] micros,
    output logic [31:0] millis
);
    localparam int PRESCALE = CLK_FREQ_HZ / 1000000;
    localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [9:0]    us_cnt_q, us_cnt_d;
    logic [31:0]   micros_q, micros_d;
    logic [31:0]   millis_q, millis_d;
    logic          us_tick;
    logic          ms_tick;

    // Prescaler wrap produces the micros tick; every 1000th micros tick also bumps millis.
    always_comb begin
        us_tick  = (pre_q == PW'(PRESCALE - 1));
        ms_tick  = us_tick && (us_cnt_q == 10'd999);
        pre_d    = us_tick ? '0 : pre_q + 1'b1;
        us_cnt_d = us_cnt_q;
        if (us_tick) begin
            us_cnt_d = ms_tick ? 10'd0 : us_cnt_q + 10'd1;
        end
        micros_d = micros_q + 32'(us_tick);
        millis_d = millis_q + 32'(ms_tick);
    end

    // Counter state, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q    <= '0;
            us_cnt_q <= '0;
            micros_q <= '0;
            millis_q <= '0;
        end else begin
            pre_q    <= pre_d;
            us_cnt_q <= us_cnt_d;
            micros_q <= micros_d;
            millis_q <= millis_d;
        end
    end

    assign micros = micros_q;
    assign millis = millis_q;

endmodule

// File: rtl/memory_unit.sv
// Unified instruction/data memory with byte-lane stores, extended loads,
// and an MMIO window holding the LED PWM duties and the timers.
module memory_unit
    import mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 2048,
    parameter string INIT_FILE   = "",
    parameter int    CLK_FREQ_HZ = 12000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [2:0]  func3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        misaligned,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] ram_mem [DEPTH_WORDS];
    logic [31:0] ram_rdata_q;
    logic [AW-1:0] ram_idx;
    logic        ram_we;

    logic [31:0] leds_q, leds_d;
    logic [31:0] mmio_rdata_q, mmio_rdata_d;
    rsel_t       rsel_q, rsel_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  func3_q, func3_d;
    logic        misaligned_q, misaligned_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [3:0]  pwm_q, pwm_d;

    logic        is_mmio;
    logic [3:0]  lane_mask;
    logic [31:0] lane_data;
    logic [31:0] micros;
    logic [31:0] millis;

    mmio_timers #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_timers (
        .clk    (clk),
        .reset  (reset),
        .micros (micros),
        .millis (millis)
    );

    // Decode the request: alignment, target, byte lanes, and next state of LEDs/PWM.
    always_comb begin
        is_mmio      = (address[31:4] == MMIO_BASE[31:4]);
        misaligned_d = ((func3[1:0] == 2'b01) && address[0]) ||
                       (func3[1] && (address[1:0] != 2'b00));
        ram_idx      = address[AW+1:2];

        case (func3[1:0])
            2'b00: begin
                lane_mask = 4'b0001 << address[1:0];
                lane_data = {4{write_data[7:0]}};
            end
            2'b01: begin
                lane_mask = address[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{write_data[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                lane_data = write_data;
            end
        endcase

        ram_we = write_enable && !misaligned_d && !is_mmio;

        leds_d = leds_q;
        if (write_enable && !misaligned_d && is_mmio && (address[3:2] == MMIO_LEDS[3:2])) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i]) begin
                    leds_d[i*8 +: 8] = lane_data[i*8 +: 8];
                end
            end
        end

        if (address[3:2] == MMIO_LEDS[3:2]) begin
            mmio_rdata_d = leds_q;
        end else if (address[3:2] == MMIO_MILLIS[3:2]) begin
            mmio_rdata_d = millis;
        end else if (address[3:2] == MMIO_MICROS[3:2]) begin
            mmio_rdata_d = micros;
        end else begin
            mmio_rdata_d = 32'h0;
        end

        if (misaligned_d) begin
            rsel_d = RSEL_ZERO;
        end else if (is_mmio) begin
            rsel_d = RSEL_MMIO;
        end else begin
            rsel_d = RSEL_RAM;
        end
        off_d   = address[1:0];
        func3_d = func3;

        pwm_cnt_d = pwm_cnt_q + 8'd1;
        pwm_d     = {pwm_cnt_q < leds_q[31:24], pwm_cnt_q < leds_q[23:16],
                     pwm_cnt_q < leds_q[15:8],  pwm_cnt_q < leds_q[7:0]};
    end

    // Block RAM: read-first registered read every cycle, per-lane write; no reset on contents.
    always_ff @(posedge clk) begin
        ram_rdata_q <= ram_mem[ram_idx];
        if (ram_we && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i]) begin
                    ram_mem[ram_idx][i*8 +: 8] <= lane_data[i*8 +: 8];
                end
            end
        end
    end

    // Control, MMIO and PWM registers; reset forces the load result and outputs to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_q       <= '0;
            mmio_rdata_q <= '0;
            rsel_q       <= RSEL_ZERO;
            off_q        <= '0;
            func3_q      <= '0;
            misaligned_q <= 1'b0;
            pwm_cnt_q    <= '0;
            pwm_q        <= '0;
        end else begin
            leds_q       <= leds_d;
            mmio_rdata_q <= mmio_rdata_d;
            rsel_q       <= rsel_d;
            off_q        <= off_d;
            func3_q      <= func3_d;
            misaligned_q <= misaligned_d;
            pwm_cnt_q    <= pwm_cnt_d;
            pwm_q        <= pwm_d;
        end
    end

    // Extension is applied to the registered word, so the result is ready one cycle after issue.
    always_comb begin
        case (rsel_q)
            RSEL_RAM:  read_data = load_extend(ram_rdata_q, off_q, func3_q);
            RSEL_MMIO: read_data = load_extend(mmio_rdata_q, off_q, func3_q);
            default:   read_data = 32'h0;
        endcase
    end

    assign misaligned = misaligned_q;
    assign led        = pwm_q[3];
    assign red        = pwm_q[2];
    assign green      = pwm_q[1];
    assign blue       = pwm_q[0];

endmodule

// File: tb/tb_memory_unit.sv
// Directed self-checking bench for memory_unit.
module tb_memory_unit;

    logic        clk;
    logic        reset;
    logic        write_enable;
    logic [2:0]  func3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        misaligned;
    logic        led;
    logic        red;
    logic        green;
    logic        blue;

    int checks = 0;
    int errors = 0;

    memory_unit #(
        .DEPTH_WORDS (2048),
        .INIT_FILE   (""),
        .CLK_FREQ_HZ (2000000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write_enable (write_enable),
        .func3        (func3),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data),
        .misaligned   (misaligned),
        .led          (led),
        .red          (red),
        .green        (green),
        .blue         (blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and advance past the edge that samples it.
    task automatic acc(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
        write_enable = we;
        func3        = f3;
        address      = addr;
        write_data   = wd;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int n_led;
        int n_red;
        int n_green;
        int n_blue;

        reset        = 1'b1;
        write_enable = 1'b0;
        func3        = 3'b010;
        address      = 32'h0;
        write_data   = 32'h0;
        tick();
        tick();
        chk("rst_rd", read_data, 32'h0);
        chk("rst_mis", {31'h0, misaligned}, 32'h0);
        chk("rst_pwm", {28'h0, led, red, green, blue}, 32'h0);
        reset = 1'b0;

        // Sizes and extension
        acc(1'b1, 3'b010, 32'h10, 32'h8000_00FF);
        acc(1'b0, 3'b000, 32'h10, 32'h0); chk("lb", read_data, 32'hFFFF_FFFF);
        acc(1'b0, 3'b100, 32'h10, 32'h0); chk("lbu", read_data, 32'h0000_00FF);
        acc(1'b0, 3'b001, 32'h10, 32'h0); chk("lh", read_data, 32'h0000_00FF);
        acc(1'b0, 3'b101, 32'h10, 32'h0); chk("lhu", read_data, 32'h0000_00FF);
        acc(1'b0, 3'b010, 32'h10, 32'h0); chk("lw", read_data, 32'h8000_00FF);
        acc(1'b0, 3'b001, 32'h12, 32'h0); chk("lh_hi", read_data, 32'hFFFF_8000);
        acc(1'b0, 3'b100, 32'h13, 32'h0); chk("lbu_b3", read_data, 32'h0000_0080);
        acc(1'b0, 3'b111, 32'h10, 32'h0); chk("f3_111_w", read_data, 32'h8000_00FF);

        // Byte/half stores, read-first on the write edge
        acc(1'b1, 3'b010, 32'h10, 32'h1122_3344);
        acc(1'b1, 3'b000, 32'h13, 32'h0000_00AB); chk("read_first", read_data, 32'h0000_0011);
        acc(1'b0, 3'b010, 32'h10, 32'h0); chk("sb_lw", read_data, 32'hAB22_3344);
        acc(1'b0, 3'b000, 32'h13, 32'h0); chk("sb_lb", read_data, 32'hFFFF_FFAB);
        acc(1'b1, 3'b001, 32'h12, 32'h0000_BEEF);
        acc(1'b0, 3'b010, 32'h10, 32'h0); chk("sh_lw", read_data, 32'hBEEF_3344);
        acc(1'b0, 3'b101, 32'h12, 32'h0); chk("sh_lhu", read_data, 32'h0000_BEEF);
        acc(1'b0, 3'b010, 32'h2010, 32'h0); chk("wrap", read_data, 32'hBEEF_3344);

        // Misaligned accesses
        acc(1'b1, 3'b001, 32'h11, 32'h0000_5555);
        chk("sh_mis_flag", {31'h0, misaligned}, 32'h1);
        chk("sh_mis_rd", read_data, 32'h0);
        acc(1'b0, 3'b010, 32'h10, 32'h0);
        chk("mis_clear", {31'h0, misaligned}, 32'h0);
        chk("sh_dropped", read_data, 32'hBEEF_3344);
        acc(1'b0, 3'b010, 32'h12, 32'h0);
        chk("lw_mis_flag", {31'h0, misaligned}, 32'h1);
        chk("lw_mis_rd", read_data, 32'h0);
        acc(1'b0, 3'b000, 32'h11, 32'h0);
        chk("lb_odd_ok", {31'h0, misaligned}, 32'h0);
        chk("lb_odd", read_data, 32'h0000_0033);

        // MMIO: LEDs, reserved word, RAM isolation
        acc(1'b1, 3'b010, 32'h1FF0, 32'h0102_0304);
        acc(1'b1, 3'b010, 32'hFFFF_FFF0, 32'hCAFE_F00D);
        acc(1'b0, 3'b010, 32'hFFFF_FFF0, 32'h0); chk("reserved", read_data, 32'h0);
        acc(1'b0, 3'b010, 32'h1FF0, 32'h0); chk("mmio_no_ram", read_data, 32'h0102_0304);
        acc(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h8040_2000);
        acc(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0); chk("leds_rd", read_data, 32'h8040_2000);
        n_led = 0; n_red = 0; n_green = 0; n_blue = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            n_led   += int'(led);
            n_red   += int'(red);
            n_green += int'(green);
            n_blue  += int'(blue);
        end
        chk("pwm_led", n_led, 128);
        chk("pwm_red", n_red, 64);
        chk("pwm_green", n_green, 32);
        chk("pwm_blue", n_blue, 0);
        acc(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0000_00FF);
        acc(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0); chk("leds_sb", read_data, 32'hFF40_2000);

        // Reset mid-operation
        acc(1'b1, 3'b010, 32'h20, 32'h1234_5678);
        acc(1'b0, 3'b010, 32'h10, 32'h0); chk("pre_rst_rd", read_data, 32'hBEEF_3344);
        reset = 1'b1;
        #1;
        chk("async_rd", read_data, 32'h0);
        chk("async_pwm", {28'h0, led, red, green, blue}, 32'h0);
        acc(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
        reset = 1'b0;
        acc(1'b0, 3'b010, 32'h20, 32'h0); chk("rst_store_drop", read_data, 32'h1234_5678);
        acc(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0); chk("rst_leds", read_data, 32'h0);

        // Timers from a fresh reset (2 cycles per microsecond)
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        func3   = 3'b010;
        address = 32'h0;
        repeat (1999) tick();
        acc(1'b0, 3'b010, 32'hFFFF_FFF8, 32'h0); chk("millis_pre", read_data, 32'd0);
        acc(1'b0, 3'b010, 32'hFFFF_FFF4, 32'h0); chk("micros_1000", read_data, 32'd1000);
        acc(1'b0, 3'b010, 32'hFFFF_FFF8, 32'h0); chk("millis_1", read_data, 32'd1);
        acc(1'b1, 3'b010, 32'hFFFF_FFF8, 32'h0000_FFFF);
        acc(1'b0, 3'b010, 32'hFFFF_FFF8, 32'h0); chk("millis_ro", read_data, 32'd1);
        acc(1'b0, 3'b010, 32'hFFFF_FFF4, 32'h0); chk("micros_1002", read_data, 32'd1002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
